// File: rtl/cpu_defs.sv
// Shared encodings for the CS3710 control path: FSM states, datapath select
// codes, oper/func constants (also used by the ALU controller) and fault codes.
package cpu_defs;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_RSRC = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [3:0] OP_REG     = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_BCOND   = 4'b1100;

  localparam logic [3:0] FN_LOAD  = 4'b0000;
  localparam logic [3:0] FN_STOR  = 4'b0100;
  localparam logic [3:0] FN_JAL   = 4'b1000;
  localparam logic [3:0] FN_JCOND = 4'b1100;
  localparam logic [3:0] FN_SCOND = 4'b1101;
  localparam logic [3:0] FN_LSH   = 4'b0100;
  localparam logic [3:0] FN_ASHU  = 4'b0110;

  localparam logic [1:0] FAULT_NONE        = 2'b00;
  localparam logic [1:0] FAULT_MEM_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL     = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_src_imm;
    logic       psr_we;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] oper, input logic [3:0] func);
    case (oper)
      OP_REG:     is_legal = !(func inside {4'b0000, 4'b1000, 4'b1100});
      OP_SPECIAL: is_legal = func inside {FN_LOAD, FN_STOR, FN_JAL, FN_JCOND, FN_SCOND};
      OP_SHIFT:   is_legal = (func <= 4'b0100) || (func == FN_ASHU);
      default:    is_legal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (enable) r_count <= r_count + TW'(1);
  end

  assign expired = (r_count == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the CS3710 processor with
// memory-timeout and illegal-encoding detection into a sticky FAULT state.
module cpu_control_fsm
  import cpu_defs::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] oper,
  input  logic [3:0] func,
  input  logic       cond_true,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic       psr_we,
  output logic       halted,
  output logic [1:0] fault
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_fault;
  logic [1:0] w_fault_next;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;
  logic       w_wait;
  logic       w_expired;
  logic       w_is_load;
  logic       w_is_stor;
  logic       w_reg_src;

  assign w_is_load = (oper == OP_SPECIAL) && (func == FN_LOAD);
  assign w_is_stor = (oper == OP_SPECIAL) && (func == FN_STOR);
  assign w_reg_src = (oper == OP_REG) ||
                     ((oper == OP_SHIFT) && ((func == FN_LSH) || (func == FN_ASHU)));

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    w_ctrl       = '0;
    w_next       = r_state;
    w_fault_next = r_fault;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          w_ctrl.ir_load = 1'b1;
          w_ctrl.pc_en   = 1'b1;
          w_ctrl.pc_src  = PC_INC;
          w_next         = S_DECODE;
        end else if (w_expired) begin
          w_next       = S_FAULT;
          w_fault_next = FAULT_MEM_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!is_legal(oper, func)) begin
          w_next       = S_FAULT;
          w_fault_next = FAULT_ILLEGAL;
        end else if (w_is_load || w_is_stor) begin
          w_next = S_MEM;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (oper == OP_SPECIAL) begin
          if (func == FN_JAL) begin
            w_ctrl.reg_we = 1'b1;
            w_ctrl.wb_sel = WB_PC;
            w_ctrl.pc_en  = 1'b1;
            w_ctrl.pc_src = PC_RSRC;
          end else if (func == FN_JCOND) begin
            w_ctrl.pc_en  = cond_true;
            w_ctrl.pc_src = PC_RSRC;
          end else if (func == FN_SCOND) begin
            w_ctrl.reg_we = 1'b1;
            w_ctrl.wb_sel = WB_ALU;
          end
        end else if (oper == OP_BCOND) begin
          w_ctrl.pc_en  = cond_true;
          w_ctrl.pc_src = PC_DISP;
        end else begin
          w_ctrl.reg_we      = 1'b1;
          w_ctrl.wb_sel      = WB_ALU;
          w_ctrl.psr_we      = 1'b1;
          w_ctrl.alu_src_imm = !w_reg_src;
        end
      end
      S_MEM: begin
        w_ctrl.mem_req      = 1'b1;
        w_ctrl.mem_addr_sel = 1'b1;
        w_ctrl.mem_we       = w_is_stor;
        if (mem_ready) begin
          if (w_is_load) begin
            w_ctrl.reg_we = 1'b1;
            w_ctrl.wb_sel = WB_MEM;
          end
          w_next = S_FETCH;
        end else if (w_expired) begin
          w_next       = S_FAULT;
          w_fault_next = FAULT_MEM_TIMEOUT;
        end
      end
      S_FAULT: ;
      default: w_next = S_FETCH;
    endcase
  end

  // Counter runs only while a request is stalled; any other cycle re-arms it.
  assign w_wait = w_ctrl.mem_req & ~mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~w_wait),
    .enable (w_wait),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fault <= FAULT_NONE;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_next;
    end
  end

  // Reset gates the strobes combinationally so no request or write outlives it.
  assign w_out = reset ? '0 : w_ctrl;

  assign mem_req      = w_out.mem_req;
  assign mem_we       = w_out.mem_we;
  assign mem_addr_sel = w_out.mem_addr_sel;
  assign ir_load      = w_out.ir_load;
  assign pc_en        = w_out.pc_en;
  assign pc_src       = w_out.pc_src;
  assign reg_we       = w_out.reg_we;
  assign wb_sel       = w_out.wb_sel;
  assign alu_src_imm  = w_out.alu_src_imm;
  assign psr_we       = w_out.psr_we;
  assign halted       = (r_state == S_FAULT);
  assign fault        = r_fault;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: stimulus queues the expected output vector for each cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] oper;
  logic [3:0] func;
  logic       cond_true;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_en, reg_we;
  logic       alu_src_imm, psr_we, halted;
  logic [1:0] pc_src, wb_sel, fault;

  int n_checks = 0;
  int n_errors = 0;

  string       name_q[$];
  logic [14:0] exp_q[$];

  logic [14:0] v_zero, v_fw, v_fd, v_mw, v_ld, v_sw;

  cpu_control_fsm #(.MEM_TIMEOUT(16), .TW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .oper        (oper),
    .func        (func),
    .cond_true   (cond_true),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_load     (ir_load),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .alu_src_imm (alu_src_imm),
    .psr_we      (psr_we),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Vector: req we asel irl pce pcs[2] rwe wbs[2] imm psr hlt flt[2]
  function automatic logic [14:0] mk(input logic req, input logic we, input logic asel,
                                     input logic irl, input logic pce, input logic [1:0] pcs,
                                     input logic rwe, input logic [1:0] wbs, input logic imm,
                                     input logic psr, input logic hlt, input logic [1:0] flt);
    return {req, we, asel, irl, pce, pcs, rwe, wbs, imm, psr, hlt, flt};
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got=%b expected=%b (req we asel irl pce pcs rwe wbs imm psr hlt flt)",
               name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(),
            {mem_req, mem_we, mem_addr_sel, ir_load, pc_en, pc_src, reg_we, wb_sel,
             alu_src_imm, psr_we, halted, fault},
            exp_q.pop_front());
    end
  end

  task automatic cyc(input string name, input logic [14:0] e);
    name_q.push_back(name);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] o, input logic [3:0] f, input logic c);
    oper      = o;
    func      = f;
    cond_true = c;
  endtask

  task automatic fetch(input string tag, input int waits);
    mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) cyc({tag, "_fetch_wait"}, v_fw);
    mem_ready = 1'b1;
    cyc({tag, "_fetch"}, v_fd);
  endtask

  task automatic run_exec(input string tag, input logic [3:0] o, input logic [3:0] f,
                          input logic c, input logic [14:0] e);
    set_instr(o, f, c);
    fetch(tag, 0);
    cyc({tag, "_decode"}, v_zero);
    cyc({tag, "_exec"}, e);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    cyc({tag, "_reset"}, v_zero);
    reset = 1'b0;
  endtask

  initial begin
    v_zero = '0;
    v_fw   = mk(1,0,0,0,0,2'b00,0,2'b00,0,0,0,2'b00);
    v_fd   = mk(1,0,0,1,1,2'b00,0,2'b00,0,0,0,2'b00);
    v_mw   = mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0,2'b00);
    v_ld   = mk(1,0,1,0,0,2'b00,1,2'b01,0,0,0,2'b00);
    v_sw   = mk(1,1,1,0,0,2'b00,0,2'b00,0,0,0,2'b00);

    reset = 1'b1;
    mem_ready = 1'b1;
    set_instr(4'b0000, 4'b0101, 1'b0);
    @(posedge clk);
    #1;
    cyc("reset_hold", v_zero);
    cyc("reset_hold2", v_zero);
    reset = 1'b0;

    // ALU group: register, immediate, register shift, immediate shift, Scond
    run_exec("add",  4'b0000, 4'b0101, 1'b0, mk(0,0,0,0,0,2'b00,1,2'b00,0,1,0,2'b00));
    run_exec("addi", 4'b0101, 4'b0011, 1'b0, mk(0,0,0,0,0,2'b00,1,2'b00,1,1,0,2'b00));
    run_exec("lsh",  4'b1000, 4'b0100, 1'b0, mk(0,0,0,0,0,2'b00,1,2'b00,0,1,0,2'b00));
    run_exec("lshi", 4'b1000, 4'b0000, 1'b0, mk(0,0,0,0,0,2'b00,1,2'b00,1,1,0,2'b00));
    run_exec("lui",  4'b1111, 4'b1010, 1'b0, mk(0,0,0,0,0,2'b00,1,2'b00,1,1,0,2'b00));
    run_exec("scond",4'b0100, 4'b1101, 1'b1, mk(0,0,0,0,0,2'b00,1,2'b00,0,0,0,2'b00));

    // LOAD with three wait states
    set_instr(4'b0100, 4'b0000, 1'b0);
    fetch("load", 0);
    cyc("load_decode", v_zero);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("load_mem_wait", v_mw);
    mem_ready = 1'b1;
    cyc("load_mem_done", v_ld);

    // STOR with one wait state
    set_instr(4'b0100, 4'b0100, 1'b0);
    fetch("stor", 0);
    cyc("stor_decode", v_zero);
    mem_ready = 1'b0;
    cyc("stor_mem_wait", v_sw);
    mem_ready = 1'b1;
    cyc("stor_mem_done", v_sw);

    // Branches and jumps
    run_exec("bcond_nt", 4'b1100, 4'b0011, 1'b0, mk(0,0,0,0,0,2'b01,0,2'b00,0,0,0,2'b00));
    run_exec("bcond_t",  4'b1100, 4'b0011, 1'b1, mk(0,0,0,0,1,2'b01,0,2'b00,0,0,0,2'b00));
    run_exec("jcond_nt", 4'b0100, 4'b1100, 1'b0, mk(0,0,0,0,0,2'b10,0,2'b00,0,0,0,2'b00));
    run_exec("jcond_t",  4'b0100, 4'b1100, 1'b1, mk(0,0,0,0,1,2'b10,0,2'b00,0,0,0,2'b00));
    run_exec("jal",      4'b0100, 4'b1000, 1'b0, mk(0,0,0,0,1,2'b10,1,2'b10,0,0,0,2'b00));

    // Illegal encodings are sticky until reset
    set_instr(4'b0100, 4'b0010, 1'b0);
    fetch("ill_spec", 0);
    cyc("ill_spec_decode", v_zero);
    cyc("ill_spec_fault", mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,2'b10));
    mem_ready = 1'b0;
    cyc("ill_spec_sticky", mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,2'b10));
    pulse_reset("ill_spec");

    set_instr(4'b1000, 4'b0111, 1'b0);
    fetch("ill_shift", 0);
    cyc("ill_shift_decode", v_zero);
    cyc("ill_shift_fault", mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,2'b10));
    pulse_reset("ill_shift");

    // Fetch timeout: 16 stalled request cycles, then FAULT
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", v_fw);
    cyc("to_fault", mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,2'b01));
    mem_ready = 1'b1;
    cyc("to_sticky", mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,2'b01));
    pulse_reset("to");

    // mem_ready in the expiry cycle completes the fetch
    set_instr(4'b0000, 4'b0101, 1'b0);
    fetch("edge", 15);
    cyc("edge_decode", v_zero);
    cyc("edge_exec", mk(0,0,0,0,0,2'b00,1,2'b00,0,1,0,2'b00));

    // Reset asserted mid-MEM of a STOR drops the strobes in the same cycle
    set_instr(4'b0100, 4'b0100, 1'b0);
    fetch("rst_stor", 0);
    cyc("rst_stor_decode", v_zero);
    mem_ready = 1'b0;
    cyc("rst_stor_mem_wait", v_sw);
    reset = 1'b1;
    cyc("rst_stor_async", v_zero);
    cyc("rst_stor_hold", v_zero);
    reset = 1'b0;
    set_instr(4'b0000, 4'b0101, 1'b0);
    fetch("rst_after", 0);
    cyc("rst_after_decode", v_zero);

    repeat (2) @(posedge clk);
    check("scoreboard_drain", 15'(exp_q.size()), 15'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
